ray_scan_ctrl: RTL
==================

RAY_SCAN_CTRL -- requirements
Module: ray_scan_ctrl

Interface
REQ-001 SHALL take parameter COLS, default 80: canvas columns, range 1..128.
REQ-002 SHALL take parameter ROWS, default 60: canvas rows, range 1..64.
REQ-003 SHALL take parameter PERIOD, default 37: ray-unit issue period in clocks.
REQ-004 SHALL take parameter CAPTURE_PH, default 35: phase at which view_out is valid for the last issued pixel, range 1..PERIOD-1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset, the same net that resets the ray unit.
REQ-007 SHALL have port start, input, 1 bit: begin a frame scan; honoured only in IDLE or DONE.
REQ-008 SHALL have port abort, input, 1 bit: synchronous return to IDLE.
REQ-009 SHALL have port view_loc, output, 13 bits: {col[6:0], row[5:0]} to the ray unit.
REQ-010 SHALL have port view_out, input, 31 bits: ray vector from the ray unit.
REQ-011 SHALL have port ray_valid, output, 1 bit: result buffer full.
REQ-012 SHALL have port ray_ready, input, 1 bit: consumer accepts the result on a cycle where ray_valid and ray_ready are both high.
REQ-013 SHALL have port ray_data, output, 31 bits: captured ray.
REQ-014 SHALL have port ray_col, output, 7 bits, and port ray_row, output, 6 bits: pixel tag of ray_data.
REQ-015 SHALL have port busy, output, 1 bit: state is RUN.
REQ-016 SHALL have port done, output, 1 bit: state is DONE.
REQ-017 SHALL have port retry_cnt, output, 16 bits: saturating count of retried pixels.

Function
REQ-018 SHALL keep phase counter ph, 0..PERIOD-1, free-running from reset and wrapping PERIOD-1 to 0; the ray unit samples view_loc on every edge where ph==0.
REQ-019 SHALL implement states IDLE, RUN and DONE; IDLE to RUN on start; RUN to DONE after the last pixel is captured; DONE to RUN on start; any state to IDLE on abort.
REQ-020 SHALL, on entry to RUN, set the pixel pointer to (col 0, row 0) and drive view_loc = {col, row} combinationally from the pointer; view_loc SHALL be 0 in IDLE.
REQ-021 SHALL, in RUN, set an issued flag at each edge with ph==0 and latch the pointer as the tag.
REQ-022 SHALL, at the edge with ph==CAPTURE_PH while issued, load {view_out, tag} into the result buffer if the buffer is empty or is popped that same cycle, then clear issued and advance the pointer.
REQ-023 SHALL, in the same case with the buffer full and not popped, drop the capture, keep the pointer, clear issued and increment retry_cnt, saturating at 0xFFFF; the same pixel is reissued next period.
REQ-024 SHALL advance the pointer row-major: col+1; on col==COLS-1, col to 0 and row+1; after (COLS-1, ROWS-1), the frame is complete.
REQ-025 SHALL change the pointer only at capture edges, so view_loc stays stable across every ph==0 sample.
REQ-026 SHALL ignore start in RUN, and SHALL give abort priority when abort and start are high in the same cycle.
REQ-027 SHALL, on abort, clear issued and the pointer but retain the result buffer contents until popped.
REQ-028 SHALL make the result buffer single-entry: a pop clears ray_valid unless the same edge reloads the buffer.
REQ-029 SHALL hold ray_data, ray_col and ray_row constant while ray_valid is high.
REQ-030 SHALL give a throughput of 1 pixel per PERIOD clocks with no backpressure.

Reset
REQ-031 SHALL, while rst is low, force ph=0, state=IDLE, issued=0, pointer=(0,0), ray_valid=0, ray_data=0, ray_col=0, ray_row=0, busy=0, done=0, retry_cnt=0 and view_loc=0.

Configuration
REQ-032 SHALL support macro RAY_SCAN_FRAME_LOOP_EN: when defined, completing the last pixel wraps the pointer to (0,0) and the block stays in RUN, with done pulsing high for 1 cycle per completed frame.
REQ-033 SHALL, when RAY_SCAN_FRAME_LOOP_EN is undefined, enter DONE after the last pixel and hold done high until start or abort.

Verification
REQ-034 SHALL cover: COLS=2, ROWS=2, ray_ready tied 1, start at ph=5 -> four results tagged (0,0), (1,0), (0,1), (1,1), one per 37 clocks, then done=1 and busy=0.
REQ-035 SHALL cover: ray_ready held 0 for 100 clocks after the first capture -> ray_data frozen, retry_cnt=2, view_loc held at (1,0), and the tag after release is (1,0).
REQ-036 SHALL cover: abort asserted while issued with a full buffer -> state=IDLE, view_loc=0, buffer still popped with the original tag.
REQ-037 SHALL cover: pop and capture on the same edge -> ray_valid stays 1 and the new tag is loaded with no retry.
REQ-038 SHALL cover: rst low mid-frame -> all outputs at reset values immediately, asynchronously, without a clock edge.
REQ-039 SHALL cover: with RAY_SCAN_FRAME_LOOP_EN defined, COLS=1, ROWS=1 -> tag (0,0) every 37 clocks and a done pulse each frame.

Source files
------------

// File: rtl/ray_scan_ctrl.sv
// rtl/ray_scan_ctrl.sv - frame scan sequencer for a fixed-period ray unit with a single-entry result buffer
// Optional feature macro: RAY_SCAN_FRAME_LOOP_EN (continuous frame looping with a per-frame done pulse)
module ray_scan_ctrl #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int PERIOD     = 37,
    parameter int CAPTURE_PH = 35
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [12:0] view_loc,
    input  logic [30:0] view_out,
    output logic        ray_valid,
    input  logic        ray_ready,
    output logic [30:0] ray_data,
    output logic [6:0]  ray_col,
    output logic [5:0]  ray_row,
    output logic        busy,
    output logic        done,
    output logic [15:0] retry_cnt
);

`ifdef RAY_SCAN_FRAME_LOOP_EN
    localparam bit FRAME_LOOP = 1'b1;
`else
    localparam bit FRAME_LOOP = 1'b0;
`endif

    localparam int            PW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PH_CAP   = PW'(CAPTURE_PH);
    localparam logic [6:0]    COL_LAST = 7'(COLS - 1);
    localparam logic [5:0]    ROW_LAST = 6'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] ph;
    logic          issued;
    logic [6:0]    col;
    logic [5:0]    row;
    logic [6:0]    tag_col;
    logic [5:0]    tag_row;
    logic          frame_pulse;

    logic cap_edge;
    logic cap_load;
    logic cap_drop;
    logic last_pix;
    logic pop;
    logic run_entry;

    assign pop       = ray_valid & ray_ready;
    assign last_pix  = (col == COL_LAST) && (row == ROW_LAST);
    assign cap_edge  = (state == S_RUN) && issued && (ph == PH_CAP) && !abort;
    assign cap_load  = cap_edge && (!ray_valid || ray_ready);
    assign cap_drop  = cap_edge && ray_valid && !ray_ready;
    assign run_entry = (state != S_RUN) && (state_nxt == S_RUN);

    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE) || frame_pulse;
    assign view_loc = (state == S_RUN) ? {col, row} : 13'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_RUN;
                S_DONE:  if (start) state_nxt = S_RUN;
                S_RUN:   if (cap_load && last_pix && !FRAME_LOOP) state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Phase counter free-runs regardless of state so the ray unit cadence never slips.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph <= '0;
        end else if (ph == PH_LAST) begin
            ph <= '0;
        end else begin
            ph <= ph + 1'b1;
        end
    end

    // Pointer only moves at capture edges, keeping view_loc stable at every ph==0 sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued      <= 1'b0;
            col         <= '0;
            row         <= '0;
            tag_col     <= '0;
            tag_row     <= '0;
            retry_cnt   <= '0;
            frame_pulse <= 1'b0;
        end else begin
            frame_pulse <= FRAME_LOOP && cap_load && last_pix;
            if (abort || run_entry) begin
                issued <= 1'b0;
                col    <= '0;
                row    <= '0;
            end else if (state == S_RUN) begin
                if (ph == '0) begin
                    issued  <= 1'b1;
                    tag_col <= col;
                    tag_row <= row;
                end
                if (cap_load) begin
                    issued <= 1'b0;
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= last_pix ? 6'd0 : row + 6'd1;
                    end else begin
                        col <= col + 7'd1;
                    end
                end else if (cap_drop) begin
                    issued <= 1'b0;
                    if (retry_cnt != 16'hFFFF) begin
                        retry_cnt <= retry_cnt + 16'd1;
                    end
                end
            end
        end
    end

    // Single-entry result buffer; survives abort so a pending result can still drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ray_valid <= 1'b0;
            ray_data  <= '0;
            ray_col   <= '0;
            ray_row   <= '0;
        end else if (cap_load) begin
            ray_valid <= 1'b1;
            ray_data  <= view_out;
            ray_col   <= tag_col;
            ray_row   <= tag_row;
        end else if (pop) begin
            ray_valid <= 1'b0;
        end
    end

endmodule
